// File: rtl/md_unit_param_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// The master drives operation requests and HI/LO writes; the slave returns status and HI/LO.
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hilo_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_wdata;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, op_a, op_b, hilo_we, hilo_sel, hilo_wdata, flush,
        input  busy, hi, lo, div_zero
    );

    modport slave (
        input  start, op, op_a, op_b, hilo_we, hilo_sel, hilo_wdata, flush,
        output busy, hi, lo, div_zero
    );
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO registers: the combinational datapath is
// evaluated on latched operands and committed when the latency counter expires.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_param_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               mul_signed, op_is_div, start_is_div;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mres;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    // Multiply: sign/zero-extend to 2*WIDTH so the truncated product is exact in both modes.
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
        case (op_q)
            OP_MADD, OP_MADDU: mres = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: mres = {hi_q, lo_q} - prod;
            default:           mres = prod;
        endcase
    end

    // Divide on magnitudes; the most-negative / -1 case wraps back to itself naturally.
    always_comb begin
        op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
        a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        b_div = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        div_zero_d   = 1'b0;
        start_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = RUN;
                    op_d    = bus.op;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    cnt_d   = start_is_div ? DIV_LOAD : MULT_LOAD;
                end else if (bus.hilo_we && !bus.start) begin
                    if (bus.hilo_sel) hi_d = bus.hilo_wdata;
                    else              lo_d = bus.hilo_wdata;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (op_is_div) begin
                        if (b_q == '0) div_zero_d = 1'b1;
                        else           {hi_d, lo_d} = {rem, quo};
                    end else begin
                        {hi_d, lo_d} = mres;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed vector table, multi-cycle corner sequences and
// randomized ops against an arithmetic reference model; a second 16-bit instance.
module tb_md_unit_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_unit_param_if #(.WIDTH(32)) s();
    md_unit_param_if #(.WIDTH(16)) s16();

    md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(s.slave));
    md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut16 (
        .clk(clk), .reset(reset), .bus(s16.slave));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output logic [31:0] nh, output logic [31:0] nl, output logic dz);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p, acc, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {mhi, mlo};
        nh = mhi;
        nl = mlo;
        dz = 1'b0;
        if (op == 3'd2 || op == 3'd3) begin
            if (b == 32'd0) dz = 1'b1;
            else if (op == 3'd2) begin
                nl = 32'(sa / sb);
                nh = 32'(sa % sb);
            end else begin
                nl = 32'(ua / ub);
                nh = 32'(ua % ub);
            end
        end else begin
            if (op == 3'd0 || op == 3'd4 || op == 3'd6) p = 64'(sa * sb);
            else p = 64'(ua * ub);
            if (op == 3'd4 || op == 3'd5) r = acc + p;
            else if (op == 3'd6 || op == 3'd7) r = acc - p;
            else r = p;
            nh = r[63:32];
            nl = r[31:0];
        end
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input string tag);
        logic [31:0] eh, el;
        logic edz;
        int n, expn, dz_early;
        model_apply(op, a, b, eh, el, edz);
        expn = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        @(negedge clk);
        s.start = 1'b1; s.op = op; s.op_a = a; s.op_b = b;
        s.hilo_we = we; s.hilo_sel = 1'b0; s.hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        s.start = 1'b0; s.hilo_we = 1'b0;
        n = 0; dz_early = 0;
        while (s.busy === 1'b1 && n < 200) begin
            n++;
            if (s.div_zero !== 1'b0) dz_early++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'(expn));
        chk({tag, " dz_while_busy"}, 64'(dz_early), 64'd0);
        chk({tag, " hi"}, {32'd0, s.hi}, {32'd0, eh});
        chk({tag, " lo"}, {32'd0, s.lo}, {32'd0, el});
        chk({tag, " div_zero"}, {63'd0, s.div_zero}, {63'd0, edz});
        @(negedge clk);
        chk({tag, " div_zero_after"}, {63'd0, s.div_zero}, 64'd0);
        mhi = eh;
        mlo = el;
    endtask

    task automatic wr_hilo(input logic sel, input logic [31:0] data);
        @(negedge clk);
        s.hilo_we = 1'b1; s.hilo_sel = sel; s.hilo_wdata = data;
        @(negedge clk);
        s.hilo_we = 1'b0;
        if (sel) mhi = data;
        else mlo = data;
    endtask

    initial begin
        vec_t tbl[7];
        logic [31:0] ph, pl, eh, el;
        logic edz;
        int n;

        tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{3'd5, 32'd1,         32'd1,         32'hFFFF_FFFE, 32'h0000_0002};
        tbl[3] = '{3'd6, 32'd2,         32'd1,         32'hFFFF_FFFE, 32'h0000_0000};
        tbl[4] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{3'd3, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003};

        s.start = 0; s.op = 0; s.op_a = 0; s.op_b = 0;
        s.hilo_we = 0; s.hilo_sel = 0; s.hilo_wdata = 0; s.flush = 0;
        s16.start = 0; s16.op = 0; s16.op_a = 0; s16.op_b = 0;
        s16.hilo_we = 0; s16.hilo_sel = 0; s16.hilo_wdata = 0; s16.flush = 0;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("reset hi", {32'd0, s.hi}, 64'd0);
        chk("reset lo", {32'd0, s.lo}, 64'd0);
        chk("reset busy", {63'd0, s.busy}, 64'd0);
        chk("reset div_zero", {63'd0, s.div_zero}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_hi", i), {32'd0, s.hi}, {32'd0, tbl[i].exp_hi});
            chk($sformatf("vec%0d tbl_lo", i), {32'd0, s.lo}, {32'd0, tbl[i].exp_lo});
        end

        // Direct writes then divide by zero: HI/LO must survive and div_zero pulse once.
        wr_hilo(1'b1, 32'h11);
        wr_hilo(1'b0, 32'h22);
        chk("mthi", {32'd0, s.hi}, 64'h11);
        chk("mtlo", {32'd0, s.lo}, 64'h22);
        run_op(3'd2, 32'd5, 32'd0, 1'b0, "divz");
        chk("divz hi kept", {32'd0, s.hi}, 64'h11);
        chk("divz lo kept", {32'd0, s.lo}, 64'h22);

        // Flush on the third busy cycle.
        ph = mhi; pl = mlo;
        @(negedge clk);
        s.start = 1'b1; s.op = 3'd2; s.op_a = 32'd50; s.op_b = 32'd3;
        @(negedge clk);
        s.start = 1'b0;
        chk("flush busy1", {63'd0, s.busy}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        s.flush = 1'b1;
        @(negedge clk);
        s.flush = 1'b0;
        chk("flush busy_low", {63'd0, s.busy}, 64'd0);
        chk("flush hi", {32'd0, s.hi}, {32'd0, ph});
        chk("flush lo", {32'd0, s.lo}, {32'd0, pl});
        @(negedge clk);
        chk("flush no_dz", {63'd0, s.div_zero}, 64'd0);
        chk("flush stays_idle", {63'd0, s.busy}, 64'd0);

        // Start and hilo_we while busy are both ignored.
        model_apply(3'd2, 32'd100, 32'd7, eh, el, edz);
        @(negedge clk);
        s.start = 1'b1; s.op = 3'd2; s.op_a = 32'd100; s.op_b = 32'd7;
        @(negedge clk);
        s.start = 1'b0;
        @(negedge clk);
        s.start = 1'b1; s.op = 3'd3; s.op_a = 32'd1000; s.op_b = 32'd3;
        s.hilo_we = 1'b1; s.hilo_sel = 1'b1; s.hilo_wdata = 32'h5555;
        @(negedge clk);
        s.start = 1'b0; s.hilo_we = 1'b0;
        n = 2;
        while (s.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_ign cycles", 64'(n), 64'd10);
        chk("busy_ign hi", {32'd0, s.hi}, {32'd0, eh});
        chk("busy_ign lo", {32'd0, s.lo}, {32'd0, el});
        @(negedge clk);
        chk("busy_ign no_relaunch", {63'd0, s.busy}, 64'd0);
        mhi = eh; mlo = el;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            int k;
            if ($urandom_range(0, 9) == 0) begin
                wr_hilo(1'($urandom_range(0, 1)), $urandom);
            end else begin
                ra = $urandom;
                k = $urandom_range(0, 7);
                if (k == 0) rb = 32'd0;
                else if (k == 1) rb = 32'($urandom_range(1, 15));
                else if (k == 2) rb = 32'hFFFF_FFFF;
                else rb = $urandom;
                run_op(3'($urandom_range(0, 7)), ra, rb, 1'b0, $sformatf("rnd%0d", i));
            end
        end

        // Reset in the middle of a multiply.
        wr_hilo(1'b1, 32'hAAAA);
        @(negedge clk);
        s.start = 1'b1; s.op = 3'd0; s.op_a = 32'd5; s.op_b = 32'd5;
        @(negedge clk);
        s.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst busy", {63'd0, s.busy}, 64'd0);
        chk("midrst hi", {32'd0, s.hi}, 64'd0);
        chk("midrst lo", {32'd0, s.lo}, 64'd0);
        repeat (6) @(negedge clk);
        chk("midrst no_result", {32'd0, s.lo}, 64'd0);
        mhi = '0; mlo = '0;

        run_op(3'd0, 32'd3, 32'd4, 1'b1, "start_we");
        chk("start_we lo", {32'd0, s.lo}, 64'd12);

        // 16-bit, single-cycle multiply instance.
        @(negedge clk);
        s16.start = 1'b1; s16.op = 3'd0; s16.op_a = 16'hFFFE; s16.op_b = 16'd3;
        @(negedge clk);
        s16.start = 1'b0;
        chk("w16 busy", {63'd0, s16.busy}, 64'd1);
        @(negedge clk);
        chk("w16 busy_low", {63'd0, s16.busy}, 64'd0);
        chk("w16 hi", {48'd0, s16.hi}, 64'hFFFF);
        chk("w16 lo", {48'd0, s16.lo}, 64'hFFFA);
        s16.start = 1'b1; s16.op = 3'd1; s16.op_a = 16'hFFFF; s16.op_b = 16'hFFFF;
        @(negedge clk);
        s16.start = 1'b0;
        @(negedge clk);
        chk("w16 multu hi", {48'd0, s16.hi}, 64'hFFFE);
        chk("w16 multu lo", {48'd0, s16.lo}, 64'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
